// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: oversampling UART receiver feeding a first-word-fall-through
// byte FIFO with a valid/ready output handshake.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity checking).
// Without it the receiver expects 8N1 framing and parity_err_o is tied low.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Start is confirmed half a bit after the falling edge, so every later
    // sample lands in the middle of its bit.
    localparam logic [15:0]   HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic        rx_meta_q;
    logic        rx_s_q;

    state_t      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,   shift_d;
    logic        frame_err_q, frame_err_d;
    logic        push_req;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q,    par_bad_d;
    logic        parity_err_q, parity_err_d;
`endif

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overrun_q, overrun_d;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;

    // Two-flop synchronizer; resets to the idle (high) line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver FSM state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Receiver FSM next state: count down to each mid-bit sample point,
    // then act on the synchronized line level.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s_q) begin
                    // Line went back high before mid-start: treat as a glitch.
                    state_d = IDLE;
                end else begin
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    // Even parity: data ones plus the parity bit must be even.
                    par_bad_d = (rx_s_q != (^shift_q));
                    cnt_d     = FULL_LOAD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s_q) begin
                    // Low stop bit: framing error; wait out any break.
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end else begin
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
`else
                    push_req = 1'b1;
`endif
                    // Returning to IDLE mid-stop lets a back-to-back start
                    // edge half a bit later be caught.
                    state_d = IDLE;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO control: push and pop honoured together even when full; a push
    // into a full FIFO with no pop is dropped and recorded as overrun.
    always_comb begin
        fifo_full = (count_q == DEPTH_CNT);
        do_pop    = (count_q != '0) && ready_i;
        do_push   = push_req && (!fifo_full || do_pop) && !rst;
        overrun_d = overrun_q || (push_req && fifo_full && !do_pop);
        wr_ptr_d  = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(do_push) - CW'(do_pop);
    end

    // FIFO pointer/occupancy registers; overrun is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Outputs: head byte shown only while valid so it reads zero when empty.
    always_comb begin
        valid_o      = (count_q != '0);
        data_o       = valid_o ? mem[rd_ptr_q] : 8'h00;
        fifo_count_o = count_q;
        overrun_o    = overrun_q;
        frame_err_o  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err_o = parity_err_q;
`else
        parity_err_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed frames into uart_rx_monitor with hand-computed
// expectations. A short bit period keeps the run small; the latency formula
// scales with CPB. Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_monitor;

    localparam int CPB   = 48;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS_AFTER_START = 10;
`else
    localparam int NBITS_AFTER_START = 9;
`endif
    // Edge 1 latches meta, edge 2 rx_s, edge 3 enters START, then half a bit
    // to the start sample and one bit per remaining sample up to the stop.
    localparam int EXP_LAT = 3 + CPB / 2 + NBITS_AFTER_START * CPB;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic [4:0] fifo_count_o;

    int n_cmp;
    int n_bad;
    int cyc;
    int start_cyc;
    int pop_cyc;
    int valid_hi;
    int fe_cnt;
    int pe_cnt;
    int pe_total;
    logic [7:0] rx_q[$];

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .fifo_count_o (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: record popped bytes and pulse activity.
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            rx_q.push_back(data_o);
            pop_cyc = cyc;
            $display("rx byte %02h popped at cycle %0d", data_o, cyc);
        end
        if (valid_o)      valid_hi = valid_hi + 1;
        if (frame_err_o)  fe_cnt   = fe_cnt + 1;
        if (parity_err_o) begin
            pe_cnt   = pe_cnt + 1;
            pe_total = pe_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (rx_q.size() > i) return {24'h0, rx_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        valid_hi = 0;
        fe_cnt   = 0;
        pe_cnt   = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_bits,
                              input logic stop_lvl, input logic par_flip);
        start_cyc = cyc;
        rx_i = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            wait_clk(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ par_flip;
        wait_clk(CPB);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx_i = stop_lvl;
        wait_clk(CPB * stop_bits);
        rx_i = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; pop_cyc = 0; start_cyc = 0;
        valid_hi = 0; fe_cnt = 0; pe_cnt = 0; pe_total = 0;
        rst = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
        wait_clk(4);

        // Reset state
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_count", fifo_count_o, 0);
        check("rst_data", data_o, 0);
        check("rst_flags", {frame_err_o, parity_err_o, overrun_o}, 0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(4);

        // 0x55 with ready high: latency and single-cycle valid
        ready_i = 1'b1;
        clear_obs();
        send_frame(8'h55, 1, 1'b1, 1'b0);
        wait_clk(5);
        check("b55_n", rx_q.size(), 1);
        check("b55_data", q_at(0), 8'h55);
        check("b55_lat_ok", ((pop_cyc - start_cyc) >= EXP_LAT - 1) &&
                            ((pop_cyc - start_cyc) <= EXP_LAT + 1), 1);
        check("b55_valid_cycles", valid_hi, 1);
        check("b55_ferr", fe_cnt, 0);

        // 0x00 then 0xFF back-to-back, held in FIFO
        ready_i = 1'b0;
        clear_obs();
        send_frame(8'h00, 1, 1'b1, 1'b0);
        send_frame(8'hFF, 1, 1'b1, 1'b0);
        wait_clk(10);
        @(negedge clk);
        check("b2b_count", fifo_count_o, 2);
        check("b2b_head", data_o, 8'h00);
        wait_clk(1);
        ready_i = 1'b1;
        wait_clk(4);
        ready_i = 1'b0;
        wait_clk(2);
        check("b2b_n", rx_q.size(), 2);
        check("b2b_first", q_at(0), 8'h00);
        check("b2b_second", q_at(1), 8'hFF);
        check("b2b_empty", fifo_count_o, 0);

        // Short low glitch: rejected at the start sample
        ready_i = 1'b1;
        clear_obs();
        rx_i = 1'b0;
        wait_clk(20);
        rx_i = 1'b1;
        wait_clk(2 * CPB);
        check("glitch_n", rx_q.size(), 0);
        check("glitch_count", fifo_count_o, 0);
        check("glitch_ferr", fe_cnt, 0);

        // 0xA3 with stop held low two bits, then a good 0x3C
        clear_obs();
        send_frame(8'hA3, 2, 1'b0, 1'b0);
        wait_clk(CPB);
        check("ferr_pulse_cycles", fe_cnt, 1);
        check("ferr_n", rx_q.size(), 0);
        check("ferr_count", fifo_count_o, 0);
        send_frame(8'h3C, 1, 1'b1, 1'b0);
        wait_clk(5);
        check("after_ferr_n", rx_q.size(), 1);
        check("after_ferr_data", q_at(0), 8'h3C);
        check("after_ferr_pulse", fe_cnt, 1);
        check("pre_overrun", overrun_o, 0);

        // 17 bytes into a 16-deep FIFO: last one lost, overrun sticks
        ready_i = 1'b0;
        clear_obs();
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1, 1'b1, 1'b0);
        end
        wait_clk(10);
        @(negedge clk);
        check("ovr_count", fifo_count_o, 16);
        check("ovr_flag", overrun_o, 1);
        check("ovr_head", data_o, 8'h01);
        wait_clk(1);
        ready_i = 1'b1;
        wait_clk(20);
        ready_i = 1'b0;
        wait_clk(2);
        check("ovr_drain_n", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_drain_%0d", i), q_at(i), 32'(i + 1));
        end
        check("ovr_drained", fifo_count_o, 0);
        check("ovr_sticky", overrun_o, 1);

        // Reset in the middle of a frame with a byte queued
        clear_obs();
        send_frame(8'h99, 1, 1'b1, 1'b0);
        wait_clk(5);
        check("pre_rst_count", fifo_count_o, 1);
        rx_i = 1'b0;
        wait_clk(3 * CPB);
        rst  = 1'b1;
        rx_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", valid_o, 0);
        check("midrst_count", fifo_count_o, 0);
        check("midrst_data", data_o, 0);
        check("midrst_flags", {frame_err_o, parity_err_o, overrun_o}, 0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2 * CPB);
        check("postrst_count", fifo_count_o, 0);
        ready_i = 1'b1;
        clear_obs();
        send_frame(8'h7E, 1, 1'b1, 1'b0);
        wait_clk(5);
        check("postrst_n", rx_q.size(), 1);
        check("postrst_data", q_at(0), 8'h7E);
        check("postrst_ferr", fe_cnt, 0);

`ifdef UART_RX_PARITY_EN
        // Flipped parity bit: one-cycle parity pulse, no byte
        clear_obs();
        send_frame(8'h5A, 1, 1'b1, 1'b1);
        wait_clk(5);
        check("perr_pulse_cycles", pe_cnt, 1);
        check("perr_n", rx_q.size(), 0);
        check("perr_ferr", fe_cnt, 0);
        send_frame(8'h5A, 1, 1'b1, 1'b0);
        wait_clk(5);
        check("after_perr_data", q_at(0), 8'h5A);
        check("after_perr_pulse", pe_cnt, 1);
`else
        check("parity_tied0", pe_total, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
